gcd_bus_host: RTL and testbench
===============================

GCD_BUS_HOST -- requirements
Module: gcd_bus_host

Interface
REQ-001 The block SHALL have parameter ADDR_A1, default 16'h0100, meaning the bus address of the first-operand register.
REQ-002 The block SHALL have parameter ADDR_A2, default 16'h0108, meaning the bus address of the second-operand register.
REQ-003 The block SHALL have parameter ADDR_CTRL, default 16'h00F0, meaning the control register; writing bit0=1 starts a computation.
REQ-004 The block SHALL have parameter ADDR_STAT, default 16'h00F8, meaning the status register; bit0=busy, bit1=done.
REQ-005 The block SHALL have parameter ADDR_RES, default 16'h0110, meaning the result register W.
REQ-006 The block SHALL have parameter POLL_GAP, default 4, meaning idle cycles between status polls (range 0..255).
REQ-007 The block SHALL have parameter TIMEOUT, default 20000, meaning the maximum cycles from the start write to done (16-bit).
REQ-008 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-009 The block SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-010 The block SHALL have port cmd_valid, input, 1, meaning the command operands are valid.
REQ-011 The block SHALL have port cmd_ready, output, 1, meaning a command is accepted this cycle.
REQ-012 The block SHALL have ports cmd_a and cmd_b, input, 32 each, meaning the operands.
REQ-013 The block SHALL have port saddress, output, 16, meaning the peripheral bus address.
REQ-014 The block SHALL have ports srd and swr, output, 1 each, meaning the single-cycle read and write strobes.
REQ-015 The block SHALL have port sdata_out, output, 32, meaning the write data that drives the peripheral's sdata_in.
REQ-016 The block SHALL have port sdata_in, input, 32, meaning the read data from the peripheral's sdata_out.
REQ-017 The block SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1), rsp_data (output, 32) and rsp_err (output, 1), meaning the result handshake.

Function
REQ-018 The state machine SHALL use the states IDLE, WR_A1, WR_A2, WR_START, RD_STAT, CHK_STAT, GAP, RD_RES, CAP_RES and RESP.
REQ-019 cmd_ready SHALL be 1 only in IDLE, and a command SHALL be accepted on a cycle with cmd_valid=1 and cmd_ready=1.
REQ-020 When an accepted command has cmd_a=0 or cmd_b=0, the block SHALL go directly to RESP with rsp_err=1 and rsp_data=0, and SHALL issue no bus strobe.
REQ-021 When both operands are nonzero, they SHALL be latched at acceptance.
REQ-022 A nonzero command SHALL produce this strobe sequence, one strobe per cycle: WR_A1 swr at ADDR_A1 with data cmd_a, WR_A2 swr at ADDR_A2 with data cmd_b, WR_START swr at ADDR_CTRL with data 32'h1.
REQ-023 srd and swr SHALL never be high in the same cycle and SHALL each be high for exactly one cycle per access.
REQ-024 Whenever no strobe is active, saddress and sdata_out SHALL be 0.
REQ-025 Read protocol: srd SHALL be asserted in RD_STAT or RD_RES, and sdata_in SHALL be sampled in the immediately following cycle (CHK_STAT or CAP_RES).
REQ-026 In CHK_STAT, if sdata_in[1]=1 the block SHALL go to RD_RES.
REQ-027 In CHK_STAT, if sdata_in[1]=0 the block SHALL go to GAP for POLL_GAP cycles and then to RD_STAT; with POLL_GAP=0 it SHALL go directly to RD_STAT.
REQ-028 In CAP_RES, rsp_data SHALL be set to sdata_in and rsp_err to 0, and the block SHALL go to RESP.
REQ-029 Timeout: a 16-bit counter SHALL clear in WR_START and increment every cycle afterwards.
REQ-030 If the timeout counter reaches TIMEOUT in any poll state before done is seen, the block SHALL go to RESP with rsp_err=1 and rsp_data=0; an in-flight srd read SHALL be completed but its data ignored.
REQ-031 A done bit seen in the same CHK_STAT cycle as the counter reaching TIMEOUT SHALL take priority over the timeout.
REQ-032 In RESP, rsp_valid SHALL be 1, and rsp_data and rsp_err SHALL be held stable until rsp_ready=1.
REQ-033 On the cycle with rsp_ready=1 in RESP, the block SHALL return to IDLE, and cmd_ready SHALL be 1 on the following cycle.
REQ-034 Nominal latency: for acceptance at cycle 0, strobes SHALL occur at cycles 1/2/3, the first srd at cycle 4, RD_RES srd at cycle 6 if done is seen on the first poll, and rsp_valid at cycle 8.
REQ-035 A response to a zero-operand command SHALL have rsp_valid at cycle 1.

Reset
REQ-036 While reset=1 at a clock edge, the block SHALL enter IDLE and set cmd_ready=1, srd=swr=0, saddress=0, sdata_out=0, rsp_valid=0, rsp_data=0, rsp_err=0, and the timeout counter to 0.
REQ-037 Reset asserted mid-operation SHALL abandon the transaction without a response and without any further strobes, including a start-abort write.

Verification
REQ-038 The bench SHALL check: cmd 48,18, with a model asserting done after 10 cycles -> writes 48, 18 and 1 at the three addresses, polls, then rsp_data=6, rsp_err=0.
REQ-039 The bench SHALL check: cmd 0,7 -> rsp_valid at cycle 1, rsp_err=1, rsp_data=0, and zero bus strobes.
REQ-040 The bench SHALL check: a model that never sets done, with TIMEOUT=50 -> rsp_err=1, rsp_data=0, and no RD_RES read.
REQ-041 The bench SHALL check: cmd 35,21 with rsp_ready held low 20 cycles -> rsp_valid, rsp_data=7 and rsp_err=0 stable throughout; IDLE follows the rsp_ready cycle.
REQ-042 The bench SHALL check: reset asserted during GAP -> the next cycle shows IDLE, no strobe and rsp_valid=0; a following cmd 12,8 returns 4.
REQ-043 The bench SHALL check: POLL_GAP=0 with done on the third poll -> back-to-back RD_STAT/CHK_STAT pairs, and srd never adjacent to swr in the same cycle.

Source files
------------

// File: rtl/gcd_bus_host.sv
// Bus master that offloads a GCD to a memory-mapped peripheral.
// It writes both operands, starts the unit, polls status with a timeout, then returns the result.
module gcd_bus_host #(
  parameter logic [15:0] ADDR_A1   = 16'h0100,
  parameter logic [15:0] ADDR_A2   = 16'h0108,
  parameter logic [15:0] ADDR_CTRL = 16'h00F0,
  parameter logic [15:0] ADDR_STAT = 16'h00F8,
  parameter logic [15:0] ADDR_RES  = 16'h0110,
  parameter int unsigned POLL_GAP  = 4,
  parameter int unsigned TIMEOUT   = 20000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  output logic [15:0] saddress,
  output logic        srd,
  output logic        swr,
  output logic [31:0] sdata_out,
  input  logic [31:0] sdata_in,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err
);

  typedef enum logic [3:0] {
    IDLE, WR_A1, WR_A2, WR_START, RD_STAT, CHK_STAT, GAP, RD_RES, CAP_RES, RESP
  } state_t;

  localparam logic [7:0]  GAP_LEN = 8'(POLL_GAP);
  localparam logic [15:0] TMO_LIM = 16'(TIMEOUT);

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [7:0]  gap_q, gap_d;
  logic [15:0] tmo_q, tmo_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        srd_q, srd_d, swr_q, swr_d;
  logic [15:0] saddress_q, saddress_d;
  logic [31:0] sdata_out_q, sdata_out_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic        tmo_hit;
  logic [15:0] tmo_inc;

  assign tmo_hit = (tmo_q >= TMO_LIM);
  // Saturate so a huge TIMEOUT can never wrap the counter back below the limit.
  assign tmo_inc = (tmo_q == 16'hFFFF) ? tmo_q : (tmo_q + 16'd1);

  // Next-state, operand latch, gap/timeout counters and response payload.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    gap_d      = gap_q;
    tmo_d      = tmo_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          rsp_data_d = 32'd0;
          if ((cmd_a == 32'd0) || (cmd_b == 32'd0)) begin
            rsp_err_d = 1'b1;
            state_d   = RESP;
          end else begin
            a_d       = cmd_a;
            b_d       = cmd_b;
            rsp_err_d = 1'b0;
            state_d   = WR_A1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WR_A1:    state_d = WR_A2;
      WR_A2:    state_d = WR_START;
      WR_START: begin
        tmo_d   = 16'd0;
        state_d = RD_STAT;
      end
      RD_STAT: begin
        tmo_d = tmo_inc;
        if (tmo_hit) begin
          rsp_data_d = 32'd0;
          rsp_err_d  = 1'b1;
          state_d    = RESP;
        end else begin
          state_d = CHK_STAT;
        end
      end
      CHK_STAT: begin
        tmo_d = tmo_inc;
        // Done wins over a timeout seen in the same cycle.
        if (sdata_in[1]) begin
          state_d = RD_RES;
        end else if (tmo_hit) begin
          rsp_data_d = 32'd0;
          rsp_err_d  = 1'b1;
          state_d    = RESP;
        end else if (GAP_LEN == 8'd0) begin
          state_d = RD_STAT;
        end else begin
          gap_d   = GAP_LEN - 8'd1;
          state_d = GAP;
        end
      end
      GAP: begin
        tmo_d = tmo_inc;
        if (tmo_hit) begin
          rsp_data_d = 32'd0;
          rsp_err_d  = 1'b1;
          state_d    = RESP;
        end else if (gap_q == 8'd0) begin
          state_d = RD_STAT;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      RD_RES: begin
        tmo_d   = tmo_inc;
        state_d = CAP_RES;
      end
      CAP_RES: begin
        rsp_data_d = sdata_in;
        rsp_err_d  = 1'b0;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus strobes and handshake flags decoded from the upcoming state so they leave a register.
  always_comb begin
    srd_d       = 1'b0;
    swr_d       = 1'b0;
    saddress_d  = 16'd0;
    sdata_out_d = 32'd0;
    cmd_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    case (state_d)
      WR_A1: begin
        swr_d       = 1'b1;
        saddress_d  = ADDR_A1;
        sdata_out_d = a_d;
      end
      WR_A2: begin
        swr_d       = 1'b1;
        saddress_d  = ADDR_A2;
        sdata_out_d = b_d;
      end
      WR_START: begin
        swr_d       = 1'b1;
        saddress_d  = ADDR_CTRL;
        sdata_out_d = 32'h1;
      end
      RD_STAT: begin
        srd_d      = 1'b1;
        saddress_d = ADDR_STAT;
      end
      RD_RES: begin
        srd_d      = 1'b1;
        saddress_d = ADDR_RES;
      end
      default: begin
        srd_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      gap_q       <= 8'd0;
      tmo_q       <= 16'd0;
      cmd_ready_q <= 1'b1;
      srd_q       <= 1'b0;
      swr_q       <= 1'b0;
      saddress_q  <= 16'd0;
      sdata_out_q <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      gap_q       <= gap_d;
      tmo_q       <= tmo_d;
      cmd_ready_q <= cmd_ready_d;
      srd_q       <= srd_d;
      swr_q       <= swr_d;
      saddress_q  <= saddress_d;
      sdata_out_q <= sdata_out_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign srd       = srd_q;
  assign swr       = swr_q;
  assign saddress  = saddress_q;
  assign sdata_out = sdata_out_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_gcd_bus_host.sv
// Directed bench for gcd_bus_host: two instances (POLL_GAP=4/TIMEOUT=50 and POLL_GAP=0)
// each talking to a small behavioural GCD peripheral.
module tb_gcd_bus_host;
  localparam logic [15:0] A1   = 16'h0100;
  localparam logic [15:0] A2   = 16'h0108;
  localparam logic [15:0] CTRL = 16'h00F0;
  localparam logic [15:0] STAT = 16'h00F8;
  localparam logic [15:0] RES  = 16'h0110;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst[2]       = '{1'b1, 1'b1};
  logic        cmd_valid[2] = '{1'b0, 1'b0};
  logic        cmd_ready[2];
  logic [31:0] cmd_a[2]     = '{32'd0, 32'd0};
  logic [31:0] cmd_b[2]     = '{32'd0, 32'd0};
  logic [15:0] saddress[2];
  logic        srd[2], swr[2];
  logic [31:0] sdata_out[2];
  logic [31:0] sdata_in[2]  = '{32'd0, 32'd0};
  logic        rsp_valid[2];
  logic        rsp_ready[2] = '{1'b0, 1'b0};
  logic [31:0] rsp_data[2];
  logic        rsp_err[2];

  int cyc = 0;
  int errs = 0;
  int checks = 0;

  gcd_bus_host #(.POLL_GAP(4), .TIMEOUT(50)) u_dut_a (
    .clk(clk), .reset(rst[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]), .saddress(saddress[0]), .srd(srd[0]), .swr(swr[0]),
    .sdata_out(sdata_out[0]), .sdata_in(sdata_in[0]), .rsp_valid(rsp_valid[0]),
    .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0]));

  gcd_bus_host #(.POLL_GAP(0)) u_dut_b (
    .clk(clk), .reset(rst[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]), .saddress(saddress[1]), .srd(srd[1]), .swr(swr[1]),
    .sdata_out(sdata_out[1]), .sdata_in(sdata_in[1]), .rsp_valid(rsp_valid[1]),
    .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1]));

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] gcd_f(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] p, q, t;
    p = x;
    q = y;
    while (q != 32'd0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  // Peripheral model: done is reported pdelay cycles after the start write unless pnever is set.
  logic [31:0] pa1[2]   = '{32'd0, 32'd0};
  logic [31:0] pa2[2]   = '{32'd0, 32'd0};
  logic        pbusy[2] = '{1'b0, 1'b0};
  int          pcnt[2]  = '{0, 0};
  int          pdelay[2];
  logic        pnever[2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic dn;
      dn = pbusy[i] && !pnever[i] && (pcnt[i] >= pdelay[i]);
      if (swr[i] && saddress[i] == A1) pa1[i] <= sdata_out[i];
      if (swr[i] && saddress[i] == A2) pa2[i] <= sdata_out[i];
      if (swr[i] && saddress[i] == CTRL && sdata_out[i][0]) begin
        pbusy[i] <= 1'b1;
        pcnt[i]  <= 0;
      end else if (pbusy[i]) begin
        pcnt[i] <= pcnt[i] + 1;
      end
      if (srd[i] && saddress[i] == STAT) sdata_in[i] <= {30'd0, dn, pbusy[i] & ~dn};
      else if (srd[i] && saddress[i] == RES) sdata_in[i] <= gcd_f(pa1[i], pa2[i]);
      else sdata_in[i] <= 32'd0;
    end
  end

  // Bus monitor: strobe counts, protocol violations, write log (A) and status-read cycles (B).
  int          n_srd[2]  = '{0, 0};
  int          n_swr[2]  = '{0, 0};
  int          n_res[2]  = '{0, 0};
  int          n_viol[2] = '{0, 0};
  logic        prev_srd[2] = '{1'b0, 1'b0};
  logic [15:0] wq_addr[$];
  logic [31:0] wq_data[$];
  int          st_cyc[$];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (srd[i] && swr[i]) n_viol[i] = n_viol[i] + 1;
      if (!srd[i] && !swr[i] && (saddress[i] != 16'd0 || sdata_out[i] != 32'd0)) n_viol[i] = n_viol[i] + 1;
      if (srd[i] && prev_srd[i]) n_viol[i] = n_viol[i] + 1;
      prev_srd[i] = srd[i];
      if (srd[i]) n_srd[i] = n_srd[i] + 1;
      if (swr[i]) n_swr[i] = n_swr[i] + 1;
      if (srd[i] && saddress[i] == RES) n_res[i] = n_res[i] + 1;
    end
    if (swr[0]) begin
      wq_addr.push_back(saddress[0]);
      wq_data.push_back(sdata_out[0]);
    end
    if (srd[1] && saddress[1] == STAT) st_cyc.push_back(cyc);
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Issue one command, wait for the response, hold rsp_ready low for 'hold' cycles, then release.
  task automatic run_cmd(input int i, input logic [31:0] a, input logic [31:0] b, input int hold,
                         output logic [31:0] d, output logic e, output int lat, output int bad);
    tick();
    check_val("cmd_ready_idle", 32'(cmd_ready[i]), 32'd1);
    cmd_a[i] = a;
    cmd_b[i] = b;
    cmd_valid[i] = 1'b1;
    tick();
    cmd_valid[i] = 1'b0;
    lat = 1;
    while (!rsp_valid[i] && lat < 2000) begin
      tick();
      lat++;
    end
    if (!rsp_valid[i]) check_val("rsp_wait_expired", 32'd0, 32'd1);
    d = rsp_data[i];
    e = rsp_err[i];
    bad = 0;
    for (int k = 0; k < hold; k++) begin
      tick();
      if (!rsp_valid[i] || rsp_data[i] !== d || rsp_err[i] !== e) bad++;
    end
    rsp_ready[i] = 1'b1;
    tick();
    rsp_ready[i] = 1'b0;
    check_val("ready_after_rsp", 32'(cmd_ready[i]), 32'd1);
    check_val("valid_after_rsp", 32'(rsp_valid[i]), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic        e;
    int          lat, bad, ws, sw, sr, sres, sq, nv;
    pdelay = '{10, 4};
    pnever = '{1'b0, 1'b0};

    repeat (3) tick();
    rst = '{1'b0, 1'b0};
    tick();
    for (int i = 0; i < 2; i++) begin
      check_val("rst_cmd_ready", 32'(cmd_ready[i]), 32'd1);
      check_val("rst_strobes", {30'd0, srd[i], swr[i]}, 32'd0);
      check_val("rst_saddress", 32'(saddress[i]), 32'd0);
      check_val("rst_sdata_out", sdata_out[i], 32'd0);
      check_val("rst_rsp", {30'd0, rsp_valid[i], rsp_err[i]}, 32'd0);
      check_val("rst_rsp_data", rsp_data[i], 32'd0);
    end

    // 48,18 with done 10 cycles after start; POLL_GAP=4 gives response at cycle 20.
    ws = wq_addr.size(); sw = n_swr[0]; sres = n_res[0];
    run_cmd(0, 32'd48, 32'd18, 0, d, e, lat, bad);
    check_val("g48_data", d, 32'd6);
    check_val("g48_err", 32'(e), 32'd0);
    check_val("g48_lat", 32'(lat), 32'd20);
    check_val("g48_nwr", 32'(n_swr[0] - sw), 32'd3);
    check_val("g48_w0_addr", 32'(wq_addr[ws]), 32'(A1));
    check_val("g48_w0_data", wq_data[ws], 32'd48);
    check_val("g48_w1_addr", 32'(wq_addr[ws+1]), 32'(A2));
    check_val("g48_w1_data", wq_data[ws+1], 32'd18);
    check_val("g48_w2_addr", 32'(wq_addr[ws+2]), 32'(CTRL));
    check_val("g48_w2_data", wq_data[ws+2], 32'd1);
    check_val("g48_res_rd", 32'(n_res[0] - sres), 32'd1);

    // Zero operand: immediate error response, no bus traffic.
    sw = n_swr[0]; sr = n_srd[0];
    run_cmd(0, 32'd0, 32'd7, 0, d, e, lat, bad);
    check_val("zero_lat", 32'(lat), 32'd1);
    check_val("zero_err", 32'(e), 32'd1);
    check_val("zero_data", d, 32'd0);
    check_val("zero_strobes", 32'((n_swr[0] - sw) + (n_srd[0] - sr)), 32'd0);

    // Peripheral never finishes: TIMEOUT=50 error, result register never read.
    pnever[0] = 1'b1;
    sres = n_res[0];
    run_cmd(0, 32'd9, 32'd6, 0, d, e, lat, bad);
    check_val("tmo_err", 32'(e), 32'd1);
    check_val("tmo_data", d, 32'd0);
    check_val("tmo_res_rd", 32'(n_res[0] - sres), 32'd0);
    check_val("tmo_lat_window", {31'd0, (lat >= 50) && (lat <= 60)}, 32'd1);
    pnever[0] = 1'b0;

    // Backpressure: response held stable while rsp_ready is low.
    run_cmd(0, 32'd35, 32'd21, 20, d, e, lat, bad);
    check_val("bp_data", d, 32'd7);
    check_val("bp_err", 32'(e), 32'd0);
    check_val("bp_unstable_cycles", 32'(bad), 32'd0);

    // Reset during GAP (cycles 6..9 after acceptance).
    tick();
    cmd_a[0] = 32'd12;
    cmd_b[0] = 32'd8;
    cmd_valid[0] = 1'b1;
    tick();
    cmd_valid[0] = 1'b0;
    repeat (6) tick();
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    check_val("mid_rst_ready", 32'(cmd_ready[0]), 32'd1);
    check_val("mid_rst_strobes", {30'd0, srd[0], swr[0]}, 32'd0);
    check_val("mid_rst_valid", 32'(rsp_valid[0]), 32'd0);
    sw = n_swr[0]; sr = n_srd[0]; nv = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (rsp_valid[0]) nv++;
    end
    check_val("post_rst_strobes", 32'((n_swr[0] - sw) + (n_srd[0] - sr)), 32'd0);
    check_val("post_rst_no_rsp", 32'(nv), 32'd0);
    run_cmd(0, 32'd12, 32'd8, 0, d, e, lat, bad);
    check_val("after_rst_data", d, 32'd4);
    check_val("after_rst_err", 32'(e), 32'd0);

    // POLL_GAP=0, done on the third poll: status reads at cycles 4,6,8, response at 12.
    sq = st_cyc.size(); sw = n_swr[1]; sr = n_srd[1];
    run_cmd(1, 32'd100, 32'd75, 0, d, e, lat, bad);
    check_val("b2b_data", d, 32'd25);
    check_val("b2b_err", 32'(e), 32'd0);
    check_val("b2b_lat", 32'(lat), 32'd12);
    check_val("b2b_polls", 32'(st_cyc.size() - sq), 32'd3);
    check_val("b2b_gap01", 32'(st_cyc[sq+1] - st_cyc[sq]), 32'd2);
    check_val("b2b_gap12", 32'(st_cyc[sq+2] - st_cyc[sq+1]), 32'd2);
    check_val("b2b_nrd", 32'(n_srd[1] - sr), 32'd4);
    check_val("b2b_nwr", 32'(n_swr[1] - sw), 32'd3);

    check_val("bus_viol_a", 32'(n_viol[0]), 32'd0);
    check_val("bus_viol_b", 32'(n_viol[1]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
